// File: rtl/axi4_full_mem.sv
// AXI4 slave scratch memory: independent write and read FSMs over a simple dual-port RAM,
// FIXED/INCR/WRAP addressing, per-transaction ID return and SLVERR for bad bursts or beats.
module axi4_full_mem #(
   parameter int ID_WIDTH     = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int MEMORY_WORDS = 256
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int MW_W   = $clog2(MEMORY_WORDS);
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEMORY_WORDS];

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] s, inc, win, base;
      s    = ONE << size;
      inc  = (addr & ~(s - ONE)) + s;
      win  = s * (ADDR_WIDTH'(len) + ONE);
      base = addr & ~(win - ONE);
      case (burst)
         2'b00:   return addr;
         2'b10:   return (inc == base + win) ? base : inc;
         default: return inc;
      endcase
   endfunction

   // Whole-burst errors, decided once at address accept.
   function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
      logic wrap_bad;
      wrap_bad = (burst == 2'b10) &&
                 !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      return (burst == 2'b11) || wrap_bad || (size > 3'(LSB));
   endfunction

   function automatic logic oob(input logic [ADDR_WIDTH-1:0] addr);
      return 32'(addr >> LSB) >= 32'(MEMORY_WORDS);
   endfunction

   // ---------------- write channel ----------------
   w_state_t w_state, w_next;
   logic [ID_WIDTH-1:0]   w_id;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len, w_cnt;
   logic [2:0]            w_size;
   logic [1:0]            w_burst, bresp_d;
   logic                  w_bad, w_err, w_err_next, w_last, w_beat_err, w_oob;
   logic                  aw_hs, w_hs, b_hs, awready_d, wready_d, bvalid_d;

   assign aw_hs      = s_axi_awvalid & s_axi_awready;
   assign w_hs       = s_axi_wvalid & s_axi_wready;
   assign b_hs       = s_axi_bvalid & s_axi_bready;
   assign w_last     = (w_cnt == w_len);
   assign w_oob      = oob(w_addr);
   assign w_beat_err = w_bad | w_oob | (s_axi_wlast != w_last);
   assign w_err_next = aw_hs ? 1'b0 : (w_err | (w_hs & w_beat_err));
   assign s_axi_bid  = w_id;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= 2'b00;
      end else begin
         w_state       <= w_next;
         s_axi_awready <= awready_d;
         s_axi_wready  <= wready_d;
         s_axi_bvalid  <= bvalid_d;
         s_axi_bresp   <= bresp_d;
      end
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_last) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they are valid the cycle the state is.
   always_comb begin
      awready_d = (w_next == W_IDLE);
      wready_d  = (w_next == W_DATA);
      bvalid_d  = (w_next == W_RESP);
      bresp_d   = (w_next == W_RESP) ? {w_err_next, 1'b0} : 2'b00;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_bad   <= 1'b0;
         w_err   <= 1'b0;
      end else begin
         w_err <= w_err_next;
         if (aw_hs) begin
            w_id    <= s_axi_awid;
            w_addr  <= s_axi_awaddr;
            w_len   <= s_axi_awlen;
            w_size  <= s_axi_awsize;
            w_burst <= s_axi_awburst;
            w_cnt   <= '0;
            w_bad   <= burst_bad(s_axi_awlen, s_axi_awsize, s_axi_awburst);
         end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (w_hs && !w_bad && !w_oob)
         for (int b = 0; b < STRB_W; b++)
            if (s_axi_wstrb[b]) mem[w_addr[LSB +: MW_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
   end

   // ---------------- read channel ----------------
   r_state_t r_state, r_next;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len, r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_bad, r_last, r_beat_err;
   logic                  ar_hs, r_hs, arready_d, rvalid_d;

   assign ar_hs      = s_axi_arvalid & s_axi_arready;
   assign r_hs       = s_axi_rvalid & s_axi_rready;
   assign r_last     = (r_cnt == r_len);
   assign r_beat_err = r_bad | oob(r_addr);
   assign s_axi_rid  = r_id;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
      end else begin
         r_state       <= r_next;
         s_axi_arready <= arready_d;
         s_axi_rvalid  <= rvalid_d;
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_FETCH;
         R_FETCH: r_next = R_DATA;
         R_DATA:  if (r_hs) r_next = r_last ? R_IDLE : R_FETCH;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready_d = (r_next == R_IDLE);
      rvalid_d  = (r_next == R_DATA);
   end

   // The RAM is read only in R_FETCH, so beat data stays put through any R stall.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_id        <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_cnt       <= '0;
         r_bad       <= 1'b0;
         s_axi_rdata <= '0;
         s_axi_rresp <= 2'b00;
         s_axi_rlast <= 1'b0;
      end else begin
         if (ar_hs) begin
            r_id    <= s_axi_arid;
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_size  <= s_axi_arsize;
            r_burst <= s_axi_arburst;
            r_cnt   <= '0;
            r_bad   <= burst_bad(s_axi_arlen, s_axi_arsize, s_axi_arburst);
         end else if (r_hs && !r_last) begin
            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
            r_cnt  <= r_cnt + 8'd1;
         end
         if (r_state == R_FETCH) begin
            s_axi_rdata <= r_beat_err ? '0 : mem[r_addr[LSB +: MW_W]];
            s_axi_rresp <= {r_beat_err, 1'b0};
            s_axi_rlast <= r_last;
         end
      end
   end
endmodule

// File: tb/tb_axi4_full_mem.sv
// Directed plus randomized bench for axi4_full_mem; a word-array reference model computes
// every beat address, response and data from the AXI burst rules.
module tb_axi4_full_mem;
   localparam int IDW = 4, DW = 32, AW = 12, MW = 256;

   logic          clk = 1'b0, rst_n = 1'b1;
   logic [IDW-1:0] awid, bid, arid, rid;
   logic [AW-1:0]  awaddr, araddr;
   logic [7:0]     awlen, arlen;
   logic [2:0]     awsize, arsize;
   logic [1:0]     awburst, arburst, bresp, rresp;
   logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic           arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0]  wdata, rdata;
   logic [3:0]     wstrb;
   logic [49:0]    outs;

   axi4_full_mem #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_WORDS(MW)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
      .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
      .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready));

   always #5 clk = ~clk;

   assign outs = {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata, bid, rid};

   int          total = 0, bad = 0;
   logic [31:0] ref_mem [MW];
   logic [31:0] wd_q[$], rd_q[$];
   logic [3:0]  ws_q[$];
   logic [1:0]  rr_q[$];
   logic [1:0]  last_bresp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int beat_addr(int a0, int len, int size, int burst, int i);
      int s, al, win, base;
      s  = 1 << size;
      al = a0 & ~(s - 1);
      if (burst == 0 || i == 0) return a0;
      if (burst == 1) return (al + i * s) % 4096;
      win  = (len + 1) * s;
      base = a0 - (a0 % win);
      return base + ((al - base + i * s) % win);
   endfunction

   function automatic bit burst_bad(int len, int size, int burst);
      return burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15})) || size > 2;
   endfunction

   task automatic do_write(input int id, input int addr, input int len, input int size,
                           input int burst, input int wlast_at, input int bdelay);
      int n, w;
      bit exp_err;
      logic [31:0] d;
      logic [3:0]  st;
      exp_err = burst_bad(len, size, burst) || (wlast_at != len);
      @(negedge clk);
      awid = 4'(id); awaddr = 12'(addr); awlen = 8'(len); awsize = 3'(size);
      awburst = 2'(burst); awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      chk("aw_accept", awready, 1);
      for (int b = 0; b <= len; b++) begin
         @(negedge clk);
         awvalid = 1'b0;
         if (wd_q.size() > 0) d = wd_q.pop_front(); else d = $urandom;
         if (ws_q.size() > 0) st = ws_q.pop_front(); else st = 4'hF;
         wdata = d; wstrb = st; wlast = (b == wlast_at); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 50) begin @(negedge clk); n++; end
         chk("w_accept", wready, 1);
         if (!wready) break;
         w = beat_addr(addr, len, size, burst, b) >> 2;
         if (w >= MW) exp_err = 1;
         else if (!burst_bad(len, size, burst))
            for (int k = 0; k < 4; k++) if (st[k]) ref_mem[w][k*8 +: 8] = d[k*8 +: 8];
      end
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
      chk("b_latency", bvalid, 1);
      for (int c = 0; c < bdelay; c++) begin
         @(negedge clk);
         chk("b_hold", {bvalid, awready}, 2'b10);
      end
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      chk("bid", bid, 64'(id));
      chk("bresp", bresp, exp_err ? 2'b10 : 2'b00);
      last_bresp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("b_done", {bvalid, awready}, 2'b01);
   endtask

   task automatic do_read(input int id, input int addr, input int len, input int size,
                          input int burst, input int stall);
      int n, lat, ns, w;
      bit bb;
      logic [31:0] ed;
      logic [1:0]  er;
      bb = burst_bad(len, size, burst);
      rd_q.delete(); rr_q.delete();
      @(negedge clk);
      arid = 4'(id); araddr = 12'(addr); arlen = 8'(len); arsize = 3'(size);
      arburst = 2'(burst); arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      chk("ar_accept", arready, 1);
      for (int b = 0; b <= len; b++) begin
         lat = 0;
         do begin @(negedge clk); arvalid = 1'b0; rready = 1'b0; lat++; end
         while (!rvalid && lat < 50);
         chk("r_latency", 64'(lat), 2);
         w = beat_addr(addr, len, size, burst, b) >> 2;
         if (bb || w >= MW) begin ed = '0; er = 2'b10; end
         else begin ed = ref_mem[w]; er = 2'b00; end
         chk("rdata", rdata, ed);
         chk("rresp", rresp, er);
         chk("rlast", rlast, 64'(b == len));
         chk("rid", rid, 64'(id));
         rd_q.push_back(rdata); rr_q.push_back(rresp);
         ns = (stall < 0) ? $urandom_range(0, 2) : stall;
         for (int c = 0; c < ns; c++) begin
            @(negedge clk);
            chk("r_hold", {rvalid, rlast, rresp, rdata}, {1'b1, 1'(b == len), er, ed});
         end
         rready = 1'b1;
      end
      @(negedge clk);
      rready = 1'b0;
      chk("r_done", {rvalid, arready}, 2'b01);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pre;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {awready, arready, wready, bvalid, rvalid}, 5'b11000);

      // fill the whole memory so the model is fully defined
      do_write(1, 0, 255, 2, 1, 255, 0);

      wd_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      do_write(5, 'h010, 3, 2, 1, 3, 0);
      do_read(5, 'h010, 3, 2, 1, 0);
      chk("incr_b0", rd_q[0], 32'h11); chk("incr_b1", rd_q[1], 32'h22);
      chk("incr_b2", rd_q[2], 32'h33); chk("incr_b3", rd_q[3], 32'h44);

      do_read(6, 'h018, 3, 2, 2, 0);
      chk("wrap_b0", rd_q[0], 32'h33); chk("wrap_b1", rd_q[1], 32'h44);
      chk("wrap_b2", rd_q[2], 32'h11); chk("wrap_b3", rd_q[3], 32'h22);
      chk("wrap_resp", rr_q[3], 2'b00);

      wd_q = '{32'h0};
      do_write(2, 'h000, 0, 2, 1, 0, 0);
      wd_q = '{32'hAABBCCDD}; ws_q = '{4'b0101};
      do_write(2, 'h000, 0, 2, 1, 0, 0);
      do_read(2, 'h000, 0, 2, 1, 0);
      chk("narrow", rd_q[0], 32'h00BB00DD);

      pre = ref_mem['h040 >> 2];
      do_write(3, 'h040, 1, 2, 3, 1, 0);
      chk("burst11_bresp", last_bresp, 2'b10);
      do_read(3, 'h040, 1, 2, 1, 0);
      chk("burst11_unchanged", rd_q[0], pre);

      do_read(4, 'h400, 0, 2, 1, 0);
      chk("oob_rdata", rd_q[0], 0);
      chk("oob_rresp", rr_q[0], 2'b10);

      do_write(7, 'h080, 3, 2, 1, 1, 0);
      chk("early_wlast_bresp", last_bresp, 2'b10);
      do_write(7, 'h080, 3, 2, 1, 3, 0);
      do_read(7, 'h080, 3, 2, 1, 0);

      fork
         do_write(8, 'h100, 3, 2, 1, 3, 0);
         do_read(9, 'h200, 3, 2, 1, 0);
      join
      do_read(8, 'h100, 3, 2, 1, 0);

      do_read(10, 'h010, 3, 2, 1, 1);
      do_write(11, 'h0C0, 1, 2, 1, 1, 5);

      for (int t = 0; t < 40; t++) begin
         int r, bu, ln, sz, ad;
         r  = $urandom_range(0, 9);
         bu = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
         ln = (bu == 2) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 7);
         sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         ad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 1023);
         for (int b = 0; b <= ln; b++) begin
            wd_q.push_back($urandom);
            ws_q.push_back(4'($urandom_range(0, 15)));
         end
         do_write($urandom_range(0, 15), ad, ln, sz, bu, ln, 0);
         do_read($urandom_range(0, 15), ad, ln, sz, bu, -1);
      end

      // asynchronous reset in the middle of a write burst
      @(negedge clk);
      awid = 4'd12; awaddr = 12'h300; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wlast = 1'b0;
      @(negedge clk);
      wdata = $urandom;
      #2 rst_n = 1'b0;
      #1 chk("reset_async_outs", outs, 0);
      wvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_mid_reset", {awready, arready, bvalid}, 3'b110);
      repeat (4) @(negedge clk);
      chk("no_stray_b", {bvalid, rvalid}, 2'b00);
      do_write(12, 'h300, 7, 2, 1, 7, 0);
      do_read(13, 'h300, 7, 2, 1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
